// File: rtl/therm_ramp_ctrl.sv
// Slew-limited sequencer for the TDC binary-to-thermometer code: walks the code one LSB per step.
// Optional macro THERM_RAMP_SETTLE_EN adds a SETTLE_CYC hold after every step.
module therm_ramp_ctrl #(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned MAXCODE    = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_target,
  output logic             req_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] code,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAXCODE);

  // Elaboration-time guard on parameter ranges
  if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
    $error("therm_ramp_ctrl: SETTLE_CYC must be within 1..255");
  end
  if (MAXCODE >= (1 << WIDTH)) begin : g_bad_maxcode
    $error("therm_ramp_ctrl: MAXCODE does not fit in WIDTH bits");
  end

`ifdef THERM_RAMP_SETTLE_EN
  localparam int unsigned      CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] code_d;
  logic [WIDTH-1:0] code_step;
  logic [WIDTH-1:0] req_clamped;
  logic             req_ready_d, busy_d, done_d;

  assign req_clamped = (32'(req_target) > MAXCODE) ? MAX_W : req_target;

  // One LSB toward the target, saturating at both ends of the legal range
  always_comb begin
    code_step = code;
    if (target_q > code) begin
      if (code != MAX_W) code_step = code + WIDTH'(1);
    end else if (code != '0) begin
      code_step = code - WIDTH'(1);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    code_d   = code;
    target_d = target_q;
`ifdef THERM_RAMP_SETTLE_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          target_d = req_clamped;
          state_d  = (req_clamped == code) ? DONE : STEP;
        end
      end
      STEP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          code_d = code_step;
`ifdef THERM_RAMP_SETTLE_EN
          cnt_d   = '0;
          state_d = SETTLE;
`else
          state_d = (code_step == target_q) ? DONE : STEP;
`endif
        end
      end
`ifdef THERM_RAMP_SETTLE_EN
      SETTLE: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = (code == target_q) ? DONE : STEP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      code      <= '0;
      target_q  <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef THERM_RAMP_SETTLE_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      code      <= code_d;
      target_q  <= target_d;
      req_ready <= req_ready_d;
      busy      <= busy_d;
      done      <= done_d;
`ifdef THERM_RAMP_SETTLE_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_therm_ramp_ctrl.sv
// Self-checking bench for therm_ramp_ctrl: directed scenarios plus random traffic
// against a timeline model (code as a function of edges since acceptance).
module tb_therm_ramp_ctrl;

  localparam int unsigned WIDTH      = 5;
  localparam int unsigned SETTLE_CYC = 4;
  localparam int unsigned MAXCODE    = 20;
`ifdef THERM_RAMP_SETTLE_EN
  localparam int P = 1 + SETTLE_CYC;
`else
  localparam int P = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req_valid = 1'b0;
  logic [WIDTH-1:0] req_target = '0;
  logic             abort = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] code;
  logic             busy;
  logic             done;

  therm_ramp_ctrl #(
    .WIDTH      (WIDTH),
    .SETTLE_CYC (SETTLE_CYC),
    .MAXCODE    (MAXCODE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_target (req_target),
    .req_ready  (req_ready),
    .abort      (abort),
    .code       (code),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a ramp is described by start, target, distance and edges elapsed
  bit m_busy;
  int m_t, m_start, m_tgt, m_d, m_code;
  int prev_code;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic int steps_at(input int t);
    int s;
    if (t < 1) return 0;
    s = (t - 1) / P + 1;
    return (s > m_d) ? m_d : s;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_t = 0; m_start = 0; m_tgt = 0; m_d = 0; m_code = 0;
  endtask

  task automatic model_step();
    int s;
    if (!m_busy) begin
      if (req_valid) begin
        m_tgt   = (int'(req_target) > int'(MAXCODE)) ? int'(MAXCODE) : int'(req_target);
        m_start = m_code;
        m_d     = (m_tgt > m_code) ? m_tgt - m_code : m_code - m_tgt;
        m_t     = 0;
        m_busy  = 1'b1;
      end
    end else if (abort) begin
      m_busy = 1'b0;
    end else begin
      m_t++;
      if (m_t > m_d * P) begin
        m_busy = 1'b0;
      end else begin
        s = steps_at(m_t);
        m_code = (m_tgt >= m_start) ? m_start + s : m_start - s;
      end
    end
  endtask

  task automatic check_all(input bit do_slew);
    int diff;
    check("code", 32'(code), 32'(m_code));
    check("req_ready", 32'(req_ready), 32'(!m_busy));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_busy && (m_t == m_d * P)));
    if (do_slew) begin
      diff = (int'(code) > prev_code) ? int'(code) - prev_code : prev_code - int'(code);
      check("slew", 32'(diff <= 1), 32'(1));
    end
    prev_code = int'(code);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all(1'b1);
  endtask

  // Entered at (or just after) a falling edge; leaves rst released shortly after a falling edge
  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; abort = 1'b0;
    model_reset();
    #1;
    check_all(1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all(1'b0);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (req_ready && !m_busy) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
    if (!ok) check("idle_timeout", 32'(0), 32'(1));
  endtask

  task automatic request(input int tgt);
    req_valid  = 1'b1;
    req_target = WIDTH'(tgt);
    cycle();
    req_valid  = 1'b0;
    wait_idle(400);
  endtask

  initial begin
    bit found;
    model_reset();
    prev_code = 0;
    #2;
    do_reset();

    request(5);
    check("ramp_up_final", 32'(code), 32'(5));
    request(2);
    check("ramp_down_final", 32'(code), 32'(2));
    request(5);
    request(5);
    check("zero_dist_final", 32'(code), 32'(5));
    request(31);
    check("clamp_final", 32'(code), 32'(MAXCODE));

    // Abort mid-ramp at code 3
    @(negedge clk);
    do_reset();
    req_valid = 1'b1; req_target = WIDTH'(10);
    cycle();
    req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_code == 3) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    if (!found) check("abort_reach_timeout", 32'(0), 32'(1));
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_code", 32'(code), 32'(3));
    check("abort_ready", 32'(req_ready), 32'(1));
    for (int i = 0; i < 8; i++) cycle();

    // Held request is only taken once the current ramp has finished
    req_valid = 1'b1; req_target = WIDTH'(4);
    cycle();
    req_target = WIDTH'(7);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_busy && m_tgt == 7) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    if (!found) check("held_accept_timeout", 32'(0), 32'(1));
    req_valid = 1'b0;
    wait_idle(400);
    check("held_final", 32'(code), 32'(7));

    // Random traffic with occasional abort and mid-ramp reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        req_valid  = ($urandom_range(0, 3) == 0);
        req_target = WIDTH'($urandom_range(0, 31));
        abort      = ($urandom_range(0, 24) == 0);
        cycle();
      end
    end
    req_valid = 1'b0; abort = 1'b0;
    wait_idle(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
